// File: rtl/sdram_wish_tester_if.sv
// Host-side Wishbone link between the SDRAM self-tester (master) and the SDRAM bridge (slave).
interface sdram_wish_tester_if;
  logic        stb;
  logic        we;
  logic [31:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        cyc;

  modport master (output stb, we, addr, wdata, input rdata, cyc);
  modport slave  (input stb, we, addr, wdata, output rdata, cyc);
endinterface

// File: rtl/sdram_wish_tester.sv
// Wishbone write/read-back tester for the SDRAM bridge.
// Define SDRAM_WISH_TESTER_LFSR_EN to replace the address-XOR-seed pattern with a 16-bit LFSR.
module sdram_wish_tester #(
  parameter int          LEN_W     = 24,
  parameter int          ERR_W     = 16,
  parameter logic [31:0] ADDR_STEP = 32'd1
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [31:0]          base_addr_i,
  input  logic [LEN_W-1:0]     length_i,
  input  logic [15:0]          seed_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [ERR_W-1:0]     err_count_o,
  output logic [31:0]          first_err_addr_o,
  sdram_wish_tester_if.master  wb
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, REPORT} state_t;

  state_t           state;
  logic [31:0]      base_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] index;
  logic [15:0]      seed_q;

  logic [31:0]      addr_next;
  logic             last;
  logic [15:0]      pat_cur;
  logic [15:0]      pat_next;
  logic [15:0]      pat_start;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;

  assign addr_next = wb.addr + ADDR_STEP;
  assign last      = (LEN_W'(index + 1'b1) == len_q);
  assign mismatch  = (wb.rdata != pat_cur);
  assign err_next  = (err_count_o == '1) ? err_count_o : err_count_o + ERR_W'(1);

`ifdef SDRAM_WISH_TESTER_LFSR_EN
  logic [15:0] lfsr;

  // Fibonacci taps 16,15,13,4; the all-zero lock-up state is never loaded.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
  endfunction

  function automatic logic [15:0] lfsr_seed(input logic [15:0] s);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  assign pat_cur   = lfsr;
  assign pat_next  = lfsr_step(lfsr);
  assign pat_start = lfsr_seed(seed_i);

  always_ff @(posedge clk_i) begin
    if (!rst_n)
      lfsr <= '0;
    else if (state == IDLE && start_i)
      lfsr <= lfsr_seed(seed_i);
    else if (state == WR_WAIT && !wb.cyc && last)
      lfsr <= lfsr_seed(seed_q);
    else if ((state == WR_WAIT || state == RD_WAIT) && !wb.cyc && !last)
      lfsr <= lfsr_step(lfsr);
  end
`else
  assign pat_cur   = wb.addr[15:0]   ^ seed_q;
  assign pat_next  = addr_next[15:0] ^ seed_q;
  assign pat_start = base_addr_i[15:0] ^ seed_i;
`endif

  // NOTE: state and outputs are registers, so every assignment here is non-blocking.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state            <= IDLE;
      base_q           <= '0;
      len_q            <= '0;
      index            <= '0;
      seed_q           <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      pass_o           <= 1'b0;
      err_count_o      <= '0;
      first_err_addr_o <= '0;
      wb.stb           <= 1'b0;
      wb.we            <= 1'b0;
      wb.addr          <= '0;
      wb.wdata         <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          base_q           <= base_addr_i;
          len_q            <= length_i;
          seed_q           <= seed_i;
          index            <= '0;
          err_count_o      <= '0;
          first_err_addr_o <= '0;
          if (length_i != '0) begin
            state    <= WR_REQ;
            busy_o   <= 1'b1;
            pass_o   <= 1'b0;
            wb.stb   <= 1'b1;
            wb.we    <= 1'b1;
            wb.addr  <= base_addr_i;
            wb.wdata <= pat_start;
          end else begin
            state  <= REPORT;
            done_o <= 1'b1;
            pass_o <= 1'b1;
          end
        end

        WR_REQ: if (wb.cyc) begin
          wb.stb <= 1'b0;
          state  <= WR_WAIT;
        end

        WR_WAIT: if (!wb.cyc) begin
          wb.stb <= 1'b1;
          if (last) begin
            index    <= '0;
            state    <= RD_REQ;
            wb.we    <= 1'b0;
            wb.addr  <= base_q;
            wb.wdata <= '0;
          end else begin
            index    <= index + 1'b1;
            state    <= WR_REQ;
            wb.addr  <= addr_next;
            wb.wdata <= pat_next;
          end
        end

        RD_REQ: if (wb.cyc) begin
          wb.stb <= 1'b0;
          state  <= RD_WAIT;
        end

        // Read data is valid in the cycle the bridge drops cyc.
        RD_WAIT: if (!wb.cyc) begin
          if (mismatch) begin
            err_count_o <= err_next;
            if (err_count_o == '0)
              first_err_addr_o <= wb.addr;
          end
          if (last) begin
            state  <= REPORT;
            done_o <= 1'b1;
            busy_o <= 1'b0;
            pass_o <= !mismatch && (err_count_o == '0);
          end else begin
            index   <= index + 1'b1;
            state   <= RD_REQ;
            wb.stb  <= 1'b1;
            wb.addr <= addr_next;
          end
        end

        REPORT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_wish_tester.sv
// Directed bench for sdram_wish_tester: transaction-level bridge/memory model plus result scoreboard.
module tb_sdram_wish_tester;
  localparam int          LEN_W     = 24;
  localparam int          ERR_W     = 16;
  localparam logic [31:0] ADDR_STEP = 32'd1;

  logic             clk_i = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_i = 1'b0;
  logic [31:0]      base_addr_i = '0;
  logic [LEN_W-1:0] length_i = '0;
  logic [15:0]      seed_i = '0;
  logic             busy_o, done_o, pass_o;
  logic [ERR_W-1:0] err_count_o;
  logic [31:0]      first_err_addr_o;

  sdram_wish_tester_if bus ();

  sdram_wish_tester #(.LEN_W(LEN_W), .ERR_W(ERR_W), .ADDR_STEP(ADDR_STEP)) dut (
    .clk_i            (clk_i),
    .rst_n            (rst_n),
    .start_i          (start_i),
    .base_addr_i      (base_addr_i),
    .length_i         (length_i),
    .seed_i           (seed_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .pass_o           (pass_o),
    .err_count_o      (err_count_o),
    .first_err_addr_o (first_err_addr_o),
    .wb               (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [15:0] dat;
  } req_t;

  int          vectors = 0;
  int          miscompares = 0;
  req_t        exp_q[$];
  logic [31:0] seen_addr[$];
  logic [15:0] seen_dat[$];
  logic [15:0] mem [logic [31:0]];
  int          bridge_delay = 0;
  int          cyc_hold = 1;
  bit          corrupt_en = 1'b0;
  logic [31:0] corrupt_addr = '0;
  int          exp_err;
  logic [31:0] exp_first;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Word i pattern straight from the definition of the test pattern.
  function automatic logic [15:0] model_pat(input logic [31:0] base, input int i, input logic [15:0] seed);
`ifdef SDRAM_WISH_TESTER_LFSR_EN
    logic [15:0] s;
    s = (seed == 16'h0) ? 16'h0001 : seed;
    for (int k = 0; k < i; k++) s = {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
    return s;
`else
    logic [31:0] a;
    a = base + ADDR_STEP * 32'(i);
    return a[15:0] ^ seed;
`endif
  endfunction

  // Bridge + memory: accepts each strobe, checks it against the expected transaction list.
  initial begin : bridge
    req_t got;
    req_t want;
    bit   abort;
    bus.cyc   = 1'b0;
    bus.rdata = '0;
    forever begin
      @(posedge clk_i); #1;
      if (rst_n && bus.stb) begin
        abort = 1'b0;
        got   = '{bus.we, bus.addr, bus.wdata};
        seen_addr.push_back(got.addr);
        if (got.we) seen_dat.push_back(got.dat);
        if (exp_q.size() == 0) begin
          check("unexpected_request", 1'b1, 1'b0);
        end else begin
          want = exp_q.pop_front();
          check("req_we", got.we, want.we);
          check("req_addr", got.addr, want.addr);
          check("req_wdata", got.dat, want.dat);
        end
        for (int k = 0; k < bridge_delay && !abort; k++) begin
          @(posedge clk_i); #1;
          if (!rst_n) abort = 1'b1;
          else check("req_held_stable", {bus.stb, bus.we, bus.addr, bus.wdata},
                     {1'b1, got.we, got.addr, got.dat});
        end
        if (!abort) begin
          bus.cyc = 1'b1;
          for (int k = 0; k < cyc_hold && !abort; k++) begin
            @(posedge clk_i); #1;
            if (!rst_n) abort = 1'b1;
            else check("no_request_while_cyc", bus.stb, 1'b0);
          end
          if (!abort) begin
            if (got.we) mem[got.addr] = got.dat;
            else if (corrupt_en && got.addr == corrupt_addr) bus.rdata = 16'hFFFF;
            else bus.rdata = mem.exists(got.addr) ? mem[got.addr] : 16'hDEAD;
          end
          bus.cyc = 1'b0;
        end
      end
    end
  end

  // Every-cycle invariants on the status outputs.
  initial begin : monitor
    forever begin
      @(negedge clk_i);
      if (rst_n && bus.stb) check("busy_during_request", busy_o, 1'b1);
      if (rst_n && done_o)  check("idle_at_done", {busy_o, bus.stb}, 2'b00);
    end
  end

  task automatic run(input logic [31:0] base, input logic [LEN_W-1:0] len, input logic [15:0] seed,
                     input bit do_corrupt, input logic [31:0] caddr);
    int          cycles;
    logic [31:0] a;
    logic [15:0] p;
    exp_err   = 0;
    exp_first = '0;
    seen_addr.delete();
    seen_dat.delete();
    corrupt_en   = do_corrupt;
    corrupt_addr = caddr;
    for (int i = 0; i < int'(len); i++) begin
      a = base + ADDR_STEP * 32'(i);
      exp_q.push_back('{1'b1, a, model_pat(base, i, seed)});
    end
    for (int i = 0; i < int'(len); i++) begin
      a = base + ADDR_STEP * 32'(i);
      p = model_pat(base, i, seed);
      exp_q.push_back('{1'b0, a, 16'h0000});
      if (do_corrupt && a == caddr && p != 16'hFFFF) begin
        if (exp_err == 0) exp_first = a;
        exp_err++;
      end
    end
    @(negedge clk_i);
    start_i = 1'b1; base_addr_i = base; length_i = len; seed_i = seed;
    @(negedge clk_i);
    start_i = 1'b0; base_addr_i = 32'hA5A5_5A5A; length_i = '1; seed_i = 16'hBEEF;
    check("busy_after_start", busy_o, len != 0);
    cycles = 0;
    while (!done_o && cycles < 5000) begin
      @(negedge clk_i);
      cycles++;
    end
    check("done_seen", done_o, 1'b1);
    if (len == 0) check("len0_done_latency_ok", cycles <= 1, 1'b1);
    check("busy_at_done", busy_o, 1'b0);
    check("pass", pass_o, exp_err == 0);
    check("err_count", err_count_o, exp_err);
    check("first_err_addr", first_err_addr_o, exp_first);
    check("all_requests_issued", exp_q.size(), 0);
    @(negedge clk_i);
    check("done_one_cycle", done_o, 1'b0);
    check("pass_holds", pass_o, exp_err == 0);
  endtask

  initial begin : main
    int cycles;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_status", {busy_o, done_o, pass_o}, 3'b000);
    check("rst_err_count", err_count_o, 0);
    check("rst_first_err", first_err_addr_o, 0);
    check("rst_bus", {bus.stb, bus.we, bus.addr, bus.wdata}, 0);
    rst_n = 1'b1;
    @(negedge clk_i);

    // Ideal memory: everything reads back.
    run(32'h100, 4, 16'h0000, 1'b0, '0);
    check("t1_pass_literal", pass_o, 1'b1);
    check("t1_err_literal", err_count_o, 0);
`ifndef SDRAM_WISH_TESTER_LFSR_EN
    check("t1_wdata0", seen_dat[0], 16'h0100);
    check("t1_wdata3", seen_dat[3], 16'h0103);
`endif

    // One corrupted read word.
    run(32'h100, 4, 16'h0000, 1'b1, 32'h102);
    check("t2_pass_literal", pass_o, 1'b0);
    check("t2_err_literal", err_count_o, 1);
    check("t2_first_literal", first_err_addr_o, 32'h102);

    // Zero length: immediate report, results cleared by the start.
    run(32'h500, 0, 16'h7777, 1'b0, '0);
    check("t3_pass_literal", pass_o, 1'b1);
    check("t3_err_cleared", err_count_o, 0);

    // Slow bridge: requests must hold until cyc is seen.
    bridge_delay = 5; cyc_hold = 3;
    run(32'h40, 3, 16'hA5A5, 1'b0, '0);
    bridge_delay = 0; cyc_hold = 1;

    // Address wrap-around.
    run(32'hFFFF_FFFE, 4, 16'h5555, 1'b0, '0);
    check("t5_addr0", seen_addr[0], 32'hFFFF_FFFE);
    check("t5_addr1", seen_addr[1], 32'hFFFF_FFFF);
    check("t5_addr2", seen_addr[2], 32'h0000_0000);
    check("t5_addr3", seen_addr[3], 32'h0000_0001);
    check("t5_pass_literal", pass_o, 1'b1);

    // Reset during the third write.
    for (int i = 0; i < 4; i++)
      exp_q.push_back('{1'b1, 32'h200 + 32'(i), model_pat(32'h200, i, 16'h1234)});
    @(negedge clk_i);
    start_i = 1'b1; base_addr_i = 32'h200; length_i = 4; seed_i = 16'h1234;
    @(negedge clk_i);
    start_i = 1'b0;
    cycles = 0;
    while (!(bus.stb && bus.we && bus.addr == 32'h202) && cycles < 200) begin
      @(negedge clk_i);
      cycles++;
    end
    check("t6_third_write_seen", bus.addr, 32'h202);
    rst_n = 1'b0;
    @(negedge clk_i);
    check("t6_stb_after_rst", bus.stb, 1'b0);
    check("t6_busy_after_rst", busy_o, 1'b0);
    check("t6_err_after_rst", err_count_o, 0);
    rst_n = 1'b1;
    exp_q.delete();

    // Recovery run with a stalled bridge and a corrupted word.
    bridge_delay = 2;
    run(32'h300, 5, 16'h0F0F, 1'b1, 32'h303);
    bridge_delay = 0;
    check("t7_err_literal", err_count_o, 1);
    check("t7_first_literal", first_err_addr_o, 32'h303);

    // Idle reset clears held results.
    rst_n = 1'b0;
    @(negedge clk_i);
    check("t8_results_cleared", {pass_o, err_count_o, first_err_addr_o}, 0);
    rst_n = 1'b1;
    @(negedge clk_i);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
